// File: rtl/perip_rgb_pwm.sv
// RGB LED PWM with blink gating plus a square-wave buzzer, fed by the five
// control words of the register slave. Every control word is shadowed at a period boundary.
`timescale 1ns/1ps
module perip_rgb_pwm #(
  parameter int PWM_PERIOD  = 1000,
  parameter bit LED_ACT_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] LED_FREQ,
  input  logic [31:0] BZ_FREQ,
  input  logic [31:0] LEDR_Puty,
  input  logic [31:0] LEDG_Puty,
  input  logic [31:0] LEDB_Puty,
  output logic        LEDR_out,
  output logic        LEDG_out,
  output logic        LEDB_out,
  output logic        BZ_out,
  output logic        frame_sync
);

  localparam logic [15:0] LAST_CNT  = 16'(PWM_PERIOD - 1);
  localparam logic [15:0] PERIOD_16 = 16'(PWM_PERIOD);
  localparam logic [31:0] PERIOD_32 = 32'(PWM_PERIOD);

  typedef enum logic {IDLE, RUN} tog_state_t;

  // Saturate at the full 32-bit width so large words never alias to a short duty.
  function automatic logic [15:0] clamp_duty(input logic [31:0] puty);
    return (puty > PERIOD_32) ? PERIOD_16 : puty[15:0];
  endfunction

  logic [15:0] pwm_cnt;
  logic [15:0] duty_r_sh, duty_g_sh, duty_b_sh;
  logic        wrap;

  tog_state_t  blink_state, blink_state_nx;
  logic [31:0] blink_cnt, blink_cnt_nx, blink_hp_sh, blink_hp_nx;
  logic        blink_on, blink_on_nx;

  tog_state_t  bz_state, bz_state_nx;
  logic [31:0] bz_cnt, bz_cnt_nx, bz_hp_sh, bz_hp_nx;
  logic        bz_lvl, bz_lvl_nx;

  assign wrap = (pwm_cnt == LAST_CNT);

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    blink_state_nx = blink_state;
    blink_cnt_nx   = blink_cnt;
    blink_hp_nx    = blink_hp_sh;
    blink_on_nx    = blink_on;
    unique case (blink_state)
      IDLE: begin
        blink_on_nx  = 1'b1;
        blink_cnt_nx = '0;
        blink_hp_nx  = LED_FREQ;
        if (LED_FREQ != '0) blink_state_nx = RUN;
      end
      RUN: begin
        if (blink_cnt == blink_hp_sh - 32'd1) begin
          blink_cnt_nx = '0;
          blink_hp_nx  = LED_FREQ;
          if (LED_FREQ == '0) begin
            blink_state_nx = IDLE;
            blink_on_nx    = 1'b1;
          end else begin
            blink_on_nx = ~blink_on;
          end
        end else begin
          blink_cnt_nx = blink_cnt + 32'd1;
        end
      end
    endcase
  end

  // Buzzer mirrors the blink machine but idles low instead of high.
  always_comb begin
    bz_state_nx = bz_state;
    bz_cnt_nx   = bz_cnt;
    bz_hp_nx    = bz_hp_sh;
    bz_lvl_nx   = bz_lvl;
    unique case (bz_state)
      IDLE: begin
        bz_lvl_nx = 1'b0;
        bz_cnt_nx = '0;
        bz_hp_nx  = BZ_FREQ;
        if (BZ_FREQ != '0) bz_state_nx = RUN;
      end
      RUN: begin
        if (bz_cnt == bz_hp_sh - 32'd1) begin
          bz_cnt_nx = '0;
          bz_hp_nx  = BZ_FREQ;
          if (BZ_FREQ == '0) begin
            bz_state_nx = IDLE;
            bz_lvl_nx   = 1'b0;
          end else begin
            bz_lvl_nx = ~bz_lvl;
          end
        end else begin
          bz_cnt_nx = bz_cnt + 32'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt     <= '0;
      duty_r_sh   <= '0;
      duty_g_sh   <= '0;
      duty_b_sh   <= '0;
      blink_state <= IDLE;
      blink_cnt   <= '0;
      blink_hp_sh <= '0;
      blink_on    <= 1'b1;
      bz_state    <= IDLE;
      bz_cnt      <= '0;
      bz_hp_sh    <= '0;
      bz_lvl      <= 1'b0;
      LEDR_out    <= LED_ACT_LOW;
      LEDG_out    <= LED_ACT_LOW;
      LEDB_out    <= LED_ACT_LOW;
      BZ_out      <= 1'b0;
      frame_sync  <= 1'b0;
    end else begin
      pwm_cnt <= wrap ? '0 : pwm_cnt + 16'd1;
      if (wrap) begin
        duty_r_sh <= clamp_duty(LEDR_Puty);
        duty_g_sh <= clamp_duty(LEDG_Puty);
        duty_b_sh <= clamp_duty(LEDB_Puty);
      end
      blink_state <= blink_state_nx;
      blink_cnt   <= blink_cnt_nx;
      blink_hp_sh <= blink_hp_nx;
      blink_on    <= blink_on_nx;
      bz_state    <= bz_state_nx;
      bz_cnt      <= bz_cnt_nx;
      bz_hp_sh    <= bz_hp_nx;
      bz_lvl      <= bz_lvl_nx;
      LEDR_out    <= ((pwm_cnt < duty_r_sh) & blink_on) ^ LED_ACT_LOW;
      LEDG_out    <= ((pwm_cnt < duty_g_sh) & blink_on) ^ LED_ACT_LOW;
      LEDB_out    <= ((pwm_cnt < duty_b_sh) & blink_on) ^ LED_ACT_LOW;
      BZ_out      <= bz_lvl;
      frame_sync  <= wrap;
    end
  end

endmodule

// File: tb/tb_perip_rgb_pwm.sv
// Directed bench for perip_rgb_pwm with PWM_PERIOD=10 and active-low LEDs.
// Expected waveforms are closed-form functions of the cycle index after each stimulus change.
`timescale 1ns/1ps
module tb_perip_rgb_pwm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] led_freq, bz_freq, ledr_puty, ledg_puty, ledb_puty;
  logic        ledr_out, ledg_out, ledb_out, bz_out, frame_sync;

  int n_tests = 0;
  int n_fail  = 0;

  perip_rgb_pwm #(.PWM_PERIOD(10), .LED_ACT_LOW(1'b1)) dut (
    .CLK        (clk),
    .RST        (rst),
    .LED_FREQ   (led_freq),
    .BZ_FREQ    (bz_freq),
    .LEDR_Puty  (ledr_puty),
    .LEDG_Puty  (ledg_puty),
    .LEDB_Puty  (ledb_puty),
    .LEDR_out   (ledr_out),
    .LEDG_out   (ledg_out),
    .LEDB_out   (ledb_out),
    .BZ_out     (bz_out),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (frame_sync === 1'b1) seen = 1'b1;
    end
    check("frame_sync_wait", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_reset_levels(input string tag);
    check({tag, "_r"},  {31'd0, ledr_out},   32'd1);
    check({tag, "_g"},  {31'd0, ledg_out},   32'd1);
    check({tag, "_b"},  {31'd0, ledb_out},   32'd1);
    check({tag, "_bz"}, {31'd0, bz_out},     32'd0);
    check({tag, "_fs"}, {31'd0, frame_sync}, 32'd0);
  endtask

  // blink_on after edge j of the blink test: 25 on, 25 off, then forced on after LED_FREQ=0.
  function automatic bit blink_exp_a(input int j);
    if (j <= 25) return 1'b1;
    if (j <= 50) return 1'b0;
    return 1'b1;
  endfunction

  // bz_lvl after edge j: half-period 4, then 1 from edge 21, then silenced at edge 31.
  function automatic bit bz_exp_a(input int j);
    if (j <= 0)  return 1'b0;
    if (j <= 20) return bit'(((j - 1) / 4) % 2);
    if (j <= 30) return ((j - 21) % 2) == 0;
    return 1'b0;
  endfunction

  // After reset release: LED_FREQ=12 blink, BZ_FREQ=3 buzzer, both captured on edge 1.
  function automatic bit blink_exp_b(input int j);
    if (j < 13) return 1'b1;
    return (((j - 13) / 12) % 2) == 1;
  endfunction

  function automatic bit bz_exp_b(input int j);
    if (j < 1) return 1'b0;
    return bit'(((j - 1) / 3) % 2);
  endfunction

  initial begin
    int lows;
    int act_f1, act_f2;
    bit exp_r, exp_g, exp_b;
    rst = 1'b1;
    led_freq = '0; bz_freq = '0; ledr_puty = '0; ledg_puty = '0; ledb_puty = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_levels($sformatf("rst_hold%0d", i));
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_reset_levels($sformatf("rst_after%0d", i));
    end

    // Duty shapes: 3 cycles, 0 (never), 50 (saturated).
    ledr_puty = 32'd3; ledg_puty = 32'd0; ledb_puty = 32'd50;
    wait_fs();
    lows = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ledr_out == 1'b0) lows++;
      check($sformatf("shape_r%0d", i),  {31'd0, ledr_out},   {31'd0, !(((i - 1) % 10) < 3)});
      check($sformatf("shape_g%0d", i),  {31'd0, ledg_out},   32'd1);
      check($sformatf("shape_b%0d", i),  {31'd0, ledb_out},   32'd0);
      check($sformatf("shape_fs%0d", i), {31'd0, frame_sync}, {31'd0, (i % 10) == 0});
    end
    check("shape_r_active_cycles", lows, 6);

    // Mid-frame duty change, plus a duty word above 16 bits that must saturate.
    ledb_puty = 32'h0001_0003;
    wait_fs();
    act_f1 = 0; act_f2 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 5) ledr_puty = 32'd7;
      exp_r = !(((i - 1) % 10) < ((i <= 10) ? 3 : 7));
      if (ledr_out == 1'b0) begin
        if (i <= 10) act_f1++; else act_f2++;
      end
      check($sformatf("mid_r%0d", i),   {31'd0, ledr_out}, {31'd0, exp_r});
      check($sformatf("big_b%0d", i),   {31'd0, ledb_out}, 32'd0);
    end
    check("mid_frame1_active", act_f1, 3);
    check("mid_frame2_active", act_f2, 7);

    // Blink gating with full duty; stop the blink during an inactive half.
    ledr_puty = 32'd10;
    wait_fs();
    wait_fs();
    led_freq = 32'd25;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 30) led_freq = 32'd0;
      check($sformatf("blink_r%0d", k), {31'd0, ledr_out}, {31'd0, !blink_exp_a(k - 1)});
    end

    // Buzzer: half-period 4, then 1, then silenced.
    bz_freq = 32'd4;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 18) bz_freq = 32'd1;
      if (k == 30) bz_freq = 32'd0;
      check($sformatf("bz%0d", k), {31'd0, bz_out}, {31'd0, bz_exp_a(k - 1)});
    end

    // Reset in the middle of running blink and buzzer.
    ledg_puty = 32'd4; ledb_puty = 32'd2; led_freq = 32'd12; bz_freq = 32'd3;
    repeat (17) tick();
    rst = 1'b1;
    tick();
    check_reset_levels("midrst");
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k <= 10) begin
        exp_r = 1'b1; exp_g = 1'b1; exp_b = 1'b1;
      end else begin
        exp_r = !((((k - 1) % 10) < 10) && blink_exp_b(k - 1));
        exp_g = !((((k - 1) % 10) < 4)  && blink_exp_b(k - 1));
        exp_b = !((((k - 1) % 10) < 2)  && blink_exp_b(k - 1));
      end
      check($sformatf("post_r%0d", k),  {31'd0, ledr_out},   {31'd0, exp_r});
      check($sformatf("post_g%0d", k),  {31'd0, ledg_out},   {31'd0, exp_g});
      check($sformatf("post_b%0d", k),  {31'd0, ledb_out},   {31'd0, exp_b});
      check($sformatf("post_bz%0d", k), {31'd0, bz_out},     {31'd0, bz_exp_b(k - 1)});
      check($sformatf("post_fs%0d", k), {31'd0, frame_sync}, {31'd0, (k % 10) == 0});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
